// File: rtl/tsmp_classifier_if.sv
// Word-stream bundle for the CMC ingress path: one delimited data word plus its valid strobe.
interface tsmp_classifier_if #(
   parameter int DATA_WIDTH = 9
);
   logic [DATA_WIDTH-1:0] data;
   logic                  wr;

   modport master (output data, output wr);
   modport slave  (input  data, input  wr);
endinterface

// File: rtl/tsmp_classifier.sv
// TSMP frame classifier: tags frame heads in a fixed-latency delay line and filters per frame.
// Optional statistics counters are built when TSMP_CLASS_STATS_EN is defined.
module tsmp_classifier #(
   parameter int         DATA_WIDTH = 9,
   parameter int         ETYPE_OFS  = 12,
   parameter logic [7:0] ETYPE_HI   = 8'hff,
   parameter logic [7:0] ETYPE_LO   = 8'h01,
   parameter int         TYPE_OFS   = 14,
   parameter int         DEPTH      = 16
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   tsmp_classifier_if.slave  s_in,
   tsmp_classifier_if.master m_out,
   input  logic [1:0]        iv_mode,
   output logic              o_is_tsmp,
   output logic [7:0]        ov_type,
   output logic [15:0]       ov_tsmp_cnt,
   output logic [15:0]       ov_drop_cnt,
   output logic [15:0]       ov_err_cnt
);
   localparam int         LAST    = DEPTH - 1;
   localparam logic [7:0] EHI_IDX = 8'(ETYPE_OFS);
   localparam logic [7:0] ELO_IDX = 8'(ETYPE_OFS + 1);
   localparam logic [7:0] TYP_IDX = 8'(TYPE_OFS);
   localparam logic [7:0] AGE_MAX = 8'(DEPTH - 1);

   typedef enum logic {ST_IDLE, ST_IN_FRAME} state_t;

   function automatic logic mode_keep(input logic [1:0] mode, input logic is_tsmp);
      case (mode)
         2'd0:    return 1'b1;
         2'd1:    return is_tsmp;
         2'd2:    return !is_tsmp;
         default: return 1'b0;
      endcase
   endfunction

   state_t                state_q, state_d;
   logic                  delim, in_head, in_tail, in_acc, stray;
   logic                  hdr_q, hdr_d, mhi_q, mhi_d, mlo_q, mlo_d;
   logic [7:0]            idx_q, idx_d, age_q, age_d;
   logic                  fin, fin_tsmp, tmo;
   logic [7:0]            fin_type;

   logic                  stg_wr_q   [DEPTH];
   logic                  stg_wr_d   [DEPTH];
   logic                  stg_head_q [DEPTH];
   logic                  stg_head_d [DEPTH];
   logic [DATA_WIDTH-1:0] stg_data_q [DEPTH];
   logic [DATA_WIDTH-1:0] stg_data_d [DEPTH];
   logic                  stg_tsmp_q [DEPTH];
   logic                  stg_tsmp_d [DEPTH];
   logic [7:0]            stg_type_q [DEPTH];
   logic [7:0]            stg_type_d [DEPTH];

   logic                  out_head, keep_q, keep_d, out_wr_q, out_wr_d, tsmp_q, tsmp_d;
   logic [7:0]            type_q, type_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

   // Input tracker and header inspection; age_q is the stage the head enters on the next edge
   always_comb begin
      delim   = s_in.data[DATA_WIDTH-1];
      in_head = s_in.wr && delim && (state_q == ST_IDLE);
      in_tail = s_in.wr && delim && (state_q == ST_IN_FRAME);
      in_acc  = s_in.wr && (delim || (state_q == ST_IN_FRAME));
      stray   = s_in.wr && !delim && (state_q == ST_IDLE);

      state_d = state_q;
      if (in_head)      state_d = ST_IN_FRAME;
      else if (in_tail) state_d = ST_IDLE;

      hdr_d    = hdr_q;
      idx_d    = idx_q;
      age_d    = age_q;
      mhi_d    = mhi_q;
      mlo_d    = mlo_q;
      fin      = 1'b0;
      fin_tsmp = 1'b0;
      fin_type = 8'd0;
      tmo      = 1'b0;
      if (hdr_q) begin
         age_d = age_q + 8'd1;
         if (in_acc) begin
            idx_d = idx_q + 8'd1;
            if (idx_q == EHI_IDX) mhi_d = (s_in.data[7:0] == ETYPE_HI);
            if (idx_q == ELO_IDX) mlo_d = (s_in.data[7:0] == ETYPE_LO);
         end
         if (in_acc && (idx_q == TYP_IDX)) begin
            fin      = 1'b1;
            fin_tsmp = mhi_q && mlo_q;
            fin_type = fin_tsmp ? s_in.data[7:0] : 8'd0;
         end else if (in_tail) begin
            fin = 1'b1;
         end else if (age_q == AGE_MAX) begin
            fin = 1'b1;
            tmo = 1'b1;
         end
         if (fin) hdr_d = 1'b0;
      end
      if (in_head) begin
         hdr_d = 1'b1;
         idx_d = 8'd1;
         age_d = 8'd1;
         mhi_d = 1'b0;
         mlo_d = 1'b0;
      end
   end

   // Delay line; the verdict overrides the tag of the stage the head is moving into
   always_comb begin
      stg_wr_d[0]   = in_acc;
      stg_head_d[0] = in_head;
      stg_data_d[0] = s_in.data;
      stg_tsmp_d[0] = 1'b0;
      stg_type_d[0] = 8'd0;
      for (int i = 1; i < DEPTH; i++) begin
         stg_wr_d[i]   = stg_wr_q[i-1];
         stg_head_d[i] = stg_head_q[i-1];
         stg_data_d[i] = stg_data_q[i-1];
         stg_tsmp_d[i] = stg_tsmp_q[i-1];
         stg_type_d[i] = stg_type_q[i-1];
         if (fin && (age_q == 8'(i))) begin
            stg_tsmp_d[i] = fin_tsmp;
            stg_type_d[i] = fin_type;
         end
      end
   end

   // Output stage: tag and filter decision are taken once per head and held through the tail
   always_comb begin
      out_head = stg_wr_q[LAST] && stg_head_q[LAST];
      keep_d   = keep_q;
      tsmp_d   = tsmp_q;
      type_d   = type_q;
      if (out_head) begin
         keep_d = mode_keep(iv_mode, stg_tsmp_q[LAST]);
         tsmp_d = stg_tsmp_q[LAST];
         type_d = stg_type_q[LAST];
      end
      out_wr_d   = stg_wr_q[LAST] && keep_d;
      out_data_d = stg_data_q[LAST];
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
         hdr_q   <= 1'b0;
         idx_q   <= 8'd0;
         age_q   <= 8'd0;
         mhi_q   <= 1'b0;
         mlo_q   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            stg_wr_q[i]   <= 1'b0;
            stg_head_q[i] <= 1'b0;
         end
         keep_q     <= 1'b0;
         out_wr_q   <= 1'b0;
         tsmp_q     <= 1'b0;
         type_q     <= 8'd0;
         out_data_q <= '0;
      end else begin
         state_q <= state_d;
         hdr_q   <= hdr_d;
         idx_q   <= idx_d;
         age_q   <= age_d;
         mhi_q   <= mhi_d;
         mlo_q   <= mlo_d;
         for (int i = 0; i < DEPTH; i++) begin
            stg_wr_q[i]   <= stg_wr_d[i];
            stg_head_q[i] <= stg_head_d[i];
         end
         keep_q     <= keep_d;
         out_wr_q   <= out_wr_d;
         tsmp_q     <= tsmp_d;
         type_q     <= type_d;
         out_data_q <= out_data_d;
      end
   end

   always_ff @(posedge i_clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         stg_data_q[i] <= stg_data_d[i];
         stg_tsmp_q[i] <= stg_tsmp_d[i];
         stg_type_q[i] <= stg_type_d[i];
      end
   end

   assign m_out.data = out_data_q;
   assign m_out.wr   = out_wr_q;
   assign o_is_tsmp  = tsmp_q;
   assign ov_type    = type_q;

`ifdef TSMP_CLASS_STATS_EN
   function automatic logic [15:0] sat_inc(input logic [15:0] cnt, input logic inc);
      return (inc && (cnt != 16'hffff)) ? cnt + 16'd1 : cnt;
   endfunction

   logic [15:0] tsmp_cnt_q, tsmp_cnt_d, drop_cnt_q, drop_cnt_d, err_cnt_q, err_cnt_d;

   always_comb begin
      tsmp_cnt_d = sat_inc(tsmp_cnt_q, out_head && stg_tsmp_q[LAST]);
      drop_cnt_d = sat_inc(drop_cnt_q, out_head && !keep_d);
      err_cnt_d  = sat_inc(err_cnt_q, stray || tmo);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         tsmp_cnt_q <= 16'd0;
         drop_cnt_q <= 16'd0;
         err_cnt_q  <= 16'd0;
      end else begin
         tsmp_cnt_q <= tsmp_cnt_d;
         drop_cnt_q <= drop_cnt_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign ov_tsmp_cnt = tsmp_cnt_q;
   assign ov_drop_cnt = drop_cnt_q;
   assign ov_err_cnt  = err_cnt_q;
`else
   logic unused_stats;
   assign unused_stats = stray | tmo;
   assign ov_tsmp_cnt  = 16'd0;
   assign ov_drop_cnt  = 16'd0;
   assign ov_err_cnt   = 16'd0;
`endif
endmodule

// File: tb/tb_tsmp_classifier.sv
// Directed bench for tsmp_classifier: per-cycle vector table plus a hand-written reset sequence.
module tb_tsmp_classifier;
   localparam int DW    = 9;
   localparam int DEPTH = 16;
   localparam int VMAX  = 1024;
`ifdef TSMP_CLASS_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   typedef struct packed {
      logic        wr;
      logic [8:0]  data;
      logic [1:0]  mode;
      logic        exp_wr;
      logic [8:0]  exp_data;
      logic        chk_tag;
      logic        exp_tsmp;
      logic [7:0]  exp_type;
      logic        chk_cnt;
      logic [15:0] exp_tc;
      logic [15:0] exp_dc;
      logic [15:0] exp_ec;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  mode;
   logic        o_is_tsmp;
   logic [7:0]  ov_type;
   logic [15:0] tc, dc, ec;

   vec_t        vec [VMAX];
   int          n, last;
   logic [1:0]  cur_mode;
   int          checks, errors;

   tsmp_classifier_if #(.DATA_WIDTH(DW)) in_if ();
   tsmp_classifier_if #(.DATA_WIDTH(DW)) out_if ();

   tsmp_classifier #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .s_in        (in_if),
      .m_out       (out_if),
      .iv_mode     (mode),
      .o_is_tsmp   (o_is_tsmp),
      .ov_type     (ov_type),
      .ov_tsmp_cnt (tc),
      .ov_drop_cnt (dc),
      .ov_err_cnt  (ec)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] stat_exp(input int v);
      return STATS ? 16'(v) : 16'd0;
   endfunction

   task automatic clear_tbl();
      for (int i = 0; i < VMAX; i++) vec[i] = '0;
      n    = 0;
      last = 0;
   endtask

   task automatic put(input logic wr, input logic [8:0] d);
      vec[n].wr   = wr;
      vec[n].data = d;
      vec[n].mode = cur_mode;
      n++;
      if (n > last) last = n;
   endtask

   task automatic mark_out(input int k, input logic wr, input logic [8:0] d,
                           input logic tsmp, input logic [7:0] typ);
      int j;
      j = k + DEPTH + 1;
      vec[j].exp_wr   = wr;
      vec[j].exp_data = d;
      vec[j].chk_tag  = 1'b1;
      vec[j].exp_tsmp = tsmp;
      vec[j].exp_type = typ;
      if (j + 1 > last) last = j + 1;
   endtask

   // Words 12/13/14 carry eh/el/tb; others are seed+index. keep/tsmp/typ are the hand-given verdict.
   task automatic put_frame(input int len, input logic [7:0] seed, input logic [7:0] eh,
                            input logic [7:0] el, input logic [7:0] tb, input int gap_at,
                            input int gap_len, input logic keep, input logic tsmp,
                            input logic [7:0] typ);
      for (int i = 0; i < len; i++) begin
         logic [8:0] w;
         if (i == gap_at) begin
            for (int g = 0; g < gap_len; g++) begin
               mark_out(n, 1'b0, 9'h000, tsmp, typ);
               put(1'b0, 9'h000);
            end
         end
         w[8]   = (i == 0) || (i == len - 1);
         w[7:0] = (i == 12) ? eh : (i == 13) ? el : (i == 14) ? tb : seed + 8'(i);
         mark_out(n, keep, w, tsmp, typ);
         put(1'b1, w);
      end
   endtask

   task automatic flush(input int etc, input int edc, input int eec);
      for (int i = 0; i < DEPTH + 4; i++) put(1'b0, 9'h000);
      vec[n-1].chk_cnt = 1'b1;
      vec[n-1].exp_tc  = stat_exp(etc);
      vec[n-1].exp_dc  = stat_exp(edc);
      vec[n-1].exp_ec  = stat_exp(eec);
   endtask

   task automatic run_table();
      for (int k = 0; k < last; k++) begin
         @(negedge clk);
         chk($sformatf("wr[%0d]", k), {31'd0, out_if.wr}, {31'd0, vec[k].exp_wr});
         if (vec[k].exp_wr)
            chk($sformatf("data[%0d]", k), {23'd0, out_if.data}, {23'd0, vec[k].exp_data});
         if (vec[k].chk_tag) begin
            chk($sformatf("is_tsmp[%0d]", k), {31'd0, o_is_tsmp}, {31'd0, vec[k].exp_tsmp});
            chk($sformatf("type[%0d]", k), {24'd0, ov_type}, {24'd0, vec[k].exp_type});
         end
         if (vec[k].chk_cnt) begin
            chk($sformatf("tsmp_cnt[%0d]", k), {16'd0, tc}, {16'd0, vec[k].exp_tc});
            chk($sformatf("drop_cnt[%0d]", k), {16'd0, dc}, {16'd0, vec[k].exp_dc});
            chk($sformatf("err_cnt[%0d]", k), {16'd0, ec}, {16'd0, vec[k].exp_ec});
         end
         in_if.wr   = vec[k].wr;
         in_if.data = vec[k].data;
         mode       = vec[k].mode;
      end
      in_if.wr   = 1'b0;
      in_if.data = '0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_wr"}, {31'd0, out_if.wr}, 32'd0);
      chk({tag, "_data"}, {23'd0, out_if.data}, 32'd0);
      chk({tag, "_tsmp"}, {31'd0, o_is_tsmp}, 32'd0);
      chk({tag, "_type"}, {24'd0, ov_type}, 32'd0);
      chk({tag, "_cnts"}, {16'd0, tc | dc | ec}, 32'd0);
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      in_if.wr   = 1'b0;
      in_if.data = '0;
      mode       = 2'd0;
      cur_mode   = 2'd0;
      rst_n      = 1'b0;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst_n = 1'b1;

      clear_tbl();
      // 64-word TSMP frame, pass all
      put_frame(64, 8'h20, 8'hff, 8'h01, 8'h02, -1, 0, 1'b1, 1'b1, 8'h02);
      flush(1, 0, 0);
      // TSMP-only: IPv4 frame suppressed, back-to-back TSMP frame passed
      cur_mode = 2'd1;
      put_frame(64, 8'h40, 8'h08, 8'h00, 8'h02, -1, 0, 1'b0, 1'b0, 8'h00);
      put_frame(64, 8'h60, 8'hff, 8'h01, 8'h05, -1, 0, 1'b1, 1'b1, 8'h05);
      flush(2, 1, 0);
      // four back-to-back 5-word frames, several in flight
      cur_mode = 2'd0;
      for (int f = 0; f < 4; f++)
         put_frame(5, 8'h80 + 8'(f * 16), 8'h00, 8'h00, 8'h00, -1, 0, 1'b1, 1'b0, 8'h00);
      flush(2, 1, 0);
      // gap before type word: one cycle tolerated, two cycles time out
      put_frame(20, 8'h10, 8'hff, 8'h01, 8'h33, 14, 1, 1'b1, 1'b1, 8'h33);
      flush(3, 1, 0);
      put_frame(20, 8'h10, 8'hff, 8'h01, 8'h34, 14, 2, 1'b1, 1'b0, 8'h00);
      flush(3, 1, 1);
      // stray undelimited words in IDLE, then a clean frame
      put(1'b1, 9'h0aa);
      put(1'b1, 9'h0bb);
      put(1'b1, 9'h0cc);
      put_frame(16, 8'h50, 8'hff, 8'h01, 8'h44, -1, 0, 1'b1, 1'b1, 8'h44);
      flush(4, 1, 4);
      // non-TSMP only
      cur_mode = 2'd2;
      put_frame(16, 8'h70, 8'hff, 8'h01, 8'h07, -1, 0, 1'b0, 1'b1, 8'h07);
      put_frame(5, 8'h90, 8'h00, 8'h00, 8'h00, -1, 0, 1'b1, 1'b0, 8'h00);
      flush(5, 2, 4);
      // drop all
      cur_mode = 2'd3;
      put_frame(5, 8'ha0, 8'h00, 8'h00, 8'h00, -1, 0, 1'b0, 1'b0, 8'h00);
      flush(5, 3, 4);
      run_table();

      // Reset in the middle of a TSMP frame that is already streaming out
      mode = 2'd0;
      for (int i = 0; i < 20; i++) begin
         logic [8:0] w;
         @(negedge clk);
         w[8]   = (i == 0);
         w[7:0] = (i == 12) ? 8'hff : (i == 13) ? 8'h01 : (i == 14) ? 8'h02 : 8'(i);
         in_if.wr   = 1'b1;
         in_if.data = w;
      end
      @(negedge clk);
      chk("pre_rst_wr", {31'd0, out_if.wr}, 32'd1);
      chk("pre_rst_tsmp", {31'd0, o_is_tsmp}, 32'd1);
      chk("pre_rst_type", {24'd0, ov_type}, 32'h02);
      in_if.data = 9'h055;
      rst_n      = 1'b0;
      #1;
      chk_all_zero("rst_a");
      @(negedge clk);
      chk_all_zero("rst_b");
      @(negedge clk);
      chk_all_zero("rst_c");
      rst_n    = 1'b1;
      in_if.wr = 1'b0;

      clear_tbl();
      cur_mode = 2'd0;
      for (int i = 0; i < 5; i++) put(1'b1, 9'h0d0 + 9'(i));
      put_frame(16, 8'hc0, 8'hff, 8'h01, 8'h66, -1, 0, 1'b1, 1'b1, 8'h66);
      flush(1, 0, 5);
      run_table();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
